// File: rtl/exception_ctrl.sv
// Exception controller: latches EPC/cause, redirects fetch to the
// handler, tracks ERET return and halts on a nested fault.
module exception_ctrl #(
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] HANDLER_VEC = 32'h0000_0180,
  parameter int              CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic             pc_exception,
  input  logic [7:0]       alu_status,
  input  logic [PC_W-1:0]  pc_cur,
  input  logic             eret,
  input  logic             epc_we,
  input  logic [PC_W-1:0]  epc_wdata,
  output logic             flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  epc,
  output logic [3:0]       cause,
  output logic             in_handler,
  output logic             halted,
  output logic [CNT_W-1:0] exc_count
);

  typedef enum logic [2:0] {
    IDLE,
    TRAP,
    HANDLER,
    RET,
    HALT
  } state_t;

  state_t          state;
  logic            exc_hit;
  logic [3:0]      exc_code;
  logic [PC_W-1:0] ret_base;

  assign exc_hit = instr_valid &
                   (pc_exception | alu_status[6] |
                    alu_status[3] | alu_status[2]);

  always_comb begin
    exc_code = 4'd0;
    priority case (1'b1)
      pc_exception:  exc_code = 4'd4;
      alu_status[6]: exc_code = 4'd12;
      alu_status[3]: exc_code = 4'd9;
      alu_status[2]: exc_code = 4'd10;
      default:       exc_code = 4'd0;
    endcase
  end

  // A same-edge EPC write is the address RET returns through.
  assign ret_base = epc_we ? epc_wdata : epc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      epc            <= '0;
      cause          <= '0;
      exc_count      <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      in_handler     <= 1'b0;
      halted         <= 1'b0;
    end else begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      in_handler     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (exc_hit) begin
            state          <= TRAP;
            epc            <= pc_cur;
            cause          <= exc_code;
            if (exc_count != '1)
              exc_count <= exc_count + 1'b1;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= HANDLER_VEC;
          end
        end
        TRAP: begin
          state      <= HANDLER;
          in_handler <= 1'b1;
        end
        HANDLER: begin
          if (exc_hit) begin
            state  <= HALT;
            cause  <= exc_code;
            halted <= 1'b1;
            flush  <= 1'b1;
          end else begin
            if (epc_we)
              epc <= epc_wdata;
            if (eret) begin
              state          <= RET;
              flush          <= 1'b1;
              redirect_valid <= 1'b1;
              redirect_pc    <= ret_base + PC_W'(4);
            end else begin
              in_handler <= 1'b1;
            end
          end
        end
        RET: begin
          state <= IDLE;
        end
        HALT: begin
          flush  <= 1'b1;
          halted <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed vector bench for exception_ctrl plus a
// counter saturation sequence.
module tb_exception_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        pc_exception;
  logic [7:0]  alu_status;
  logic [31:0] pc_cur;
  logic        eret;
  logic        epc_we;
  logic [31:0] epc_wdata;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [3:0]  cause;
  logic        in_handler;
  logic        halted;
  logic [7:0]  exc_count;

  int n_chk;
  int n_pass;

  exception_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .instr_valid    (instr_valid),
    .pc_exception   (pc_exception),
    .alu_status     (alu_status),
    .pc_cur         (pc_cur),
    .eret           (eret),
    .epc_we         (epc_we),
    .epc_wdata      (epc_wdata),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .epc            (epc),
    .cause          (cause),
    .in_handler     (in_handler),
    .halted         (halted),
    .exc_count      (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        iv;
    logic        pe;
    logic [7:0]  alu;
    logic [31:0] pc;
    logic        er;
    logic        we;
    logic [31:0] wd;
    logic        fl;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] epc;
    logic [3:0]  cs;
    logic        ih;
    logic        hl;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got=%h want=%h",
                  nm, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst          = v.r;
    instr_valid  = v.iv;
    pc_exception = v.pe;
    alu_status   = v.alu;
    pc_cur       = v.pc;
    eret         = v.er;
    epc_we       = v.we;
    epc_wdata    = v.wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst = 0; instr_valid = 0; pc_exception = 0;
    alu_status = 0; pc_cur = 0; eret = 0;
    epc_we = 0; epc_wdata = 0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    idle_in();
    // r iv pe alu pc er we wd | fl rv rpc epc cs ih hl cnt
    vq.push_back('{1,0,0,8'h00,32'h0,0,0,32'h0,
                   0,0,32'h0,32'h0,0,0,0,0});
    vq.push_back('{0,1,0,8'h40,32'h1000,0,0,32'h0,
                   1,1,32'h180,32'h1000,12,0,0,1});
    vq.push_back('{0,1,1,8'h00,32'h9000,0,1,32'hABCD,
                   0,0,32'h0,32'h1000,12,1,0,1});
    vq.push_back('{0,0,0,8'h00,32'h0,1,0,32'h0,
                   1,1,32'h1004,32'h1000,12,0,0,1});
    vq.push_back('{0,0,0,8'h00,32'h0,0,0,32'h0,
                   0,0,32'h0,32'h1000,12,0,0,1});
    vq.push_back('{0,0,0,8'h00,32'h0,1,1,32'hDEAD,
                   0,0,32'h0,32'h1000,12,0,0,1});
    vq.push_back('{0,1,1,8'h0C,32'h2000,0,0,32'h0,
                   1,1,32'h180,32'h2000,4,0,0,2});
    vq.push_back('{0,0,0,8'h00,32'h0,0,0,32'h0,
                   0,0,32'h0,32'h2000,4,1,0,2});
    vq.push_back('{0,0,0,8'h00,32'h0,1,1,32'hFFFF_FFFC,
                   1,1,32'h0,32'hFFFF_FFFC,4,0,0,2});
    vq.push_back('{0,0,1,8'h0C,32'h3000,0,0,32'h0,
                   0,0,32'h0,32'hFFFF_FFFC,4,0,0,2});
    vq.push_back('{0,0,1,8'h0C,32'h3000,0,0,32'h0,
                   0,0,32'h0,32'hFFFF_FFFC,4,0,0,2});
    vq.push_back('{0,1,0,8'h08,32'h4000,0,0,32'h0,
                   1,1,32'h180,32'h4000,9,0,0,3});
    vq.push_back('{0,0,0,8'h00,32'h0,0,0,32'h0,
                   0,0,32'h0,32'h4000,9,1,0,3});
    vq.push_back('{0,1,0,8'h04,32'h5000,1,1,32'h1234,
                   1,0,32'h0,32'h4000,10,0,1,3});
    vq.push_back('{0,0,0,8'h00,32'h0,1,0,32'h0,
                   1,0,32'h0,32'h4000,10,0,1,3});
    vq.push_back('{0,1,0,8'h40,32'h6000,0,1,32'h77,
                   1,0,32'h0,32'h4000,10,0,1,3});
    vq.push_back('{1,0,0,8'h00,32'h0,0,0,32'h0,
                   0,0,32'h0,32'h0,0,0,0,0});
    vq.push_back('{0,1,0,8'h04,32'h10,0,0,32'h0,
                   1,1,32'h180,32'h10,10,0,0,1});
    vq.push_back('{1,1,0,8'h40,32'h20,0,0,32'h0,
                   0,0,32'h0,32'h0,0,0,0,0});
    vq.push_back('{0,0,0,8'h00,32'h0,0,0,32'h0,
                   0,0,32'h0,32'h0,0,0,0,0});
    vq.push_back('{0,1,0,8'h40,32'h500,0,0,32'h0,
                   1,1,32'h180,32'h500,12,0,0,1});
    vq.push_back('{0,0,0,8'h00,32'h0,0,0,32'h0,
                   0,0,32'h0,32'h500,12,1,0,1});
    vq.push_back('{0,0,0,8'h00,32'h0,1,0,32'h0,
                   1,1,32'h504,32'h500,12,0,0,1});
    vq.push_back('{0,1,0,8'h08,32'h600,0,0,32'h0,
                   0,0,32'h0,32'h500,12,0,0,1});
    vq.push_back('{0,1,0,8'h08,32'h700,0,0,32'h0,
                   1,1,32'h180,32'h700,9,0,0,2});

    foreach (vq[i]) begin
      drive(vq[i]);
      step();
      chk("flush", i, 32'(flush), 32'(vq[i].fl));
      chk("rvalid", i, 32'(redirect_valid), 32'(vq[i].rv));
      chk("rpc", i, redirect_pc, vq[i].rpc);
      chk("epc", i, epc, vq[i].epc);
      chk("cause", i, 32'(cause), 32'(vq[i].cs));
      chk("in_hdl", i, 32'(in_handler), 32'(vq[i].ih));
      chk("halted", i, 32'(halted), 32'(vq[i].hl));
      chk("count", i, 32'(exc_count), 32'(vq[i].cnt));
    end

    idle_in();
    rst = 1;
    step();
    chk("sat_rst", 0, 32'(exc_count), 32'h0);
    for (int k = 0; k < 300; k++) begin
      idle_in();
      instr_valid = 1;
      alu_status  = 8'h08;
      pc_cur      = 32'(k * 4);
      step();
      idle_in();
      if (k == 254 || k == 255 || k == 299)
        chk("sat_cnt", k, 32'(exc_count),
            (k >= 254) ? 32'd255 : 32'(k + 1));
      if (k == 0)
        chk("sat_cnt", k, 32'(exc_count), 32'd1);
      step();
      eret = 1;
      step();
      idle_in();
      step();
    end
    chk("sat_idle", 0, 32'(flush | in_handler), 32'h0);
    chk("sat_fin", 0, 32'(exc_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
